// File: rtl/mul_scheduler.sv
// mul_scheduler: arbitrates two requesters (0 = integer EX, 1 = FP unit) onto a
// single shared multiplier with a fixed latency of MUL_LAT cycles.
// Flow per operation: IDLE (grant + latch) -> ISSUE (start strobe, ack) ->
// WAIT (count down MUL_LAT) -> DONE (done pulse) -> IDLE.
// All buses use bit 0 as the MSB.
// Optional feature: define MUL_SCHEDULER_SIGNED_EN to enable signed multiply
// through sign-magnitude conversion around the unsigned multiplier.
module mul_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int W       = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0,
    input  logic           req1,
    input  logic [0:W-1]   a0,
    input  logic [0:W-1]   b0,
    input  logic [0:W-1]   a1,
    input  logic [0:W-1]   b1,
    input  logic           sgn0,
    input  logic           sgn1,
    output logic           ack0,
    output logic           ack1,
    output logic           done0,
    output logic           done1,
    output logic [0:2*W-1] result,
    output logic           busy,
    output logic           m_mul,
    output logic [0:W-1]   m_a,
    output logic [0:W-1]   m_b,
    input  logic [0:2*W-1] m_result
);

    localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          ptr;        // round-robin priority: requester favoured on a tie
    logic          grant;      // requester owning the current operation
    logic [CW-1:0] cnt;        // multiplier latency down-counter
    logic [0:W-1]  op_a;       // operands as presented to the multiplier
    logic [0:W-1]  op_b;

    logic          take;       // a grant happens at the end of this IDLE cycle
    logic          pick;       // requester chosen by the arbiter
    logic [0:W-1]  sel_a;
    logic [0:W-1]  sel_b;

    assign sel_a = pick ? a1 : a0;
    assign sel_b = pick ? b1 : b0;

`ifdef MUL_SCHEDULER_SIGNED_EN
    logic          sel_sgn;
    logic          neg;        // product must be negated on capture

    assign sel_sgn = pick ? sgn1 : sgn0;
`else
    // Sign flags have no function in the unsigned build.
    logic          unused_sgn;

    assign unused_sgn = sgn0 | sgn1;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, arbitration and all FSM-decoded outputs.
    // NOTE: every signal is given a default before the case statement so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        pick       = ptr;
        busy       = (state != IDLE);
        m_mul      = 1'b0;
        m_a        = '0;
        m_b        = '0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take       = 1'b1;
                    // Tie goes to the pointer; otherwise the only active requester.
                    pick       = (req0 && req1) ? ptr : req1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_mul      = 1'b1;
                m_a        = op_a;
                m_b        = op_b;
                ack0       = ~grant;
                ack1       = grant;
                state_next = WAIT;
            end
            WAIT: begin
                m_a = op_a;
                m_b = op_b;
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done0      = ~grant;
                done1      = grant;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, latency counter, result capture and priority pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= 1'b0;
            grant  <= 1'b0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
`ifdef MUL_SCHEDULER_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        grant <= pick;
`ifdef MUL_SCHEDULER_SIGNED_EN
                        // Magnitudes go to the multiplier; the sign is restored
                        // on capture. The most negative value is its own magnitude.
                        op_a <= (sel_sgn && sel_a[0]) ? -sel_a : sel_a;
                        op_b <= (sel_sgn && sel_b[0]) ? -sel_b : sel_b;
                        neg  <= sel_sgn && (sel_a[0] ^ sel_b[0]);
`else
                        op_a <= sel_a;
                        op_b <= sel_b;
`endif
                    end
                end
                ISSUE: begin
                    cnt <= CW'(MUL_LAT);
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
`ifdef MUL_SCHEDULER_SIGNED_EN
                        result <= neg ? -m_result : m_result;
`else
                        result <= m_result;
`endif
                    end
                end
                DONE: begin
                    ptr <= ~grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler: directed operations, a latency-exact
// multiplier model, and a scoreboard monitor that compares every done pulse
// against the expected requester and product queued by the stimulus.
module tb_mul_scheduler;

    localparam int W       = 32;
    localparam int MUL_LAT = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0, req1;
    logic [0:W-1]   a0, b0, a1, b1;
    logic           sgn0, sgn1;
    logic           ack0, ack1, done0, done1, busy, m_mul;
    logic [0:2*W-1] result;
    logic [0:W-1]   m_a, m_b;
    logic [0:2*W-1] m_result;

    typedef struct {
        int          id;
        logic [63:0] res;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    mul_scheduler #(.MUL_LAT(MUL_LAT), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .sgn0(sgn0), .sgn1(sgn1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .m_mul(m_mul), .m_a(m_a), .m_b(m_b), .m_result(m_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: product is valid only during the single cycle in
    // which the scheduler must capture it; any other cycle shows garbage.
    logic [63:0] mp       = 64'h0;
    int          age      = 0;
    logic        inflight = 1'b0;

    always @(posedge clk) begin
        if (m_mul) begin
            mp       <= {32'b0, m_a} * {32'b0, m_b};
            age      <= 0;
            inflight <= 1'b1;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    assign m_result = (inflight && age == MUL_LAT - 1) ? mp : 64'hBADC0FFEE0DDF00D;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: invariants every cycle plus scoreboard on done.
    logic [0:W-1] hold_a = '0;
    logic [0:W-1] hold_b = '0;

    task automatic monitor_cycle();
        exp_t e;
        check("ack_exclusive", {63'b0, ack0 & ack1}, 64'd0);
        check("done_exclusive", {63'b0, done0 & done1}, 64'd0);
        if (m_mul) begin
            hold_a = m_a;
            hold_b = m_b;
        end else if (busy && !done0 && !done1) begin
            check("m_a_stable", 64'(m_a), 64'(hold_a));
            check("m_b_stable", 64'(m_b), 64'(hold_b));
        end
        if (!busy) begin
            check("m_a_idle", 64'(m_a), 64'd0);
            check("m_b_idle", 64'(m_b), 64'd0);
        end
        if (done0 || done1) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done0=%0b done1=%0b result=%h", done0, done1, result);
            end else begin
                e = expq.pop_front();
                check("done_id", {63'b0, done1}, 64'(e.id));
                check("result", result, e.res);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) monitor_cycle();
    end

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
        if (id == 0) begin
            req0 = 1'b1; a0 = a; b0 = b; sgn0 = s;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; sgn1 = s;
        end
    endtask

    task automatic push(input int id, input logic [63:0] r);
        exp_t e;
        e.id  = id;
        e.res = r;
        expq.push_back(e);
    endtask

    // Waits for the requester's ack (counting negedges) and drops its req in that cycle.
    task automatic wait_ack(input int id, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if ((id == 0 && ack0) || (id == 1 && ack1)) begin
                if (id == 0) req0 = 1'b0; else req1 = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ack_timeout: requester %0d got no ack in %0d cycles", id, n);
    endtask

    task automatic wait_done(input int id, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if ((id == 0 && done0) || (id == 1 && done1)) return;
        end
        total++;
        bad++;
        $display("FAIL done_timeout: requester %0d got no done in %0d cycles", id, n);
    endtask

    task automatic run_op(input string name, input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic s, input logic [63:0] r);
        int n;
        @(negedge clk);
        set_req(id, a, b, s);
        push(id, r);
        wait_ack(id, n);
        check({name, "_ack_lat"}, 64'(n), 64'd1);
        wait_done(id, n);
        check({name, "_done_lat"}, 64'(n), 64'(MUL_LAT + 1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack0"}, {63'b0, ack0}, 64'd0);
        check({name, "_ack1"}, {63'b0, ack1}, 64'd0);
        check({name, "_done0"}, {63'b0, done0}, 64'd0);
        check({name, "_done1"}, {63'b0, done1}, 64'd0);
        check({name, "_busy"}, {63'b0, busy}, 64'd0);
        check({name, "_m_mul"}, {63'b0, m_mul}, 64'd0);
        check({name, "_m_a"}, 64'(m_a), 64'd0);
        check({name, "_m_b"}, 64'(m_b), 64'd0);
        check({name, "_result"}, result, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic early, found;

        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        sgn0 = 1'b0; sgn1 = 1'b0;

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Tie after reset: 0 first; req0 re-raised meanwhile, so 1 wins the next tie.
        @(negedge clk);
        set_req(0, 32'd2, 32'd21, 1'b0);
        set_req(1, 32'd100, 32'd100, 1'b0);
        push(0, 64'd42);
        push(1, 64'd10000);
        wait_ack(0, n);
        check("rr_ack0_lat", 64'(n), 64'd1);
        @(negedge clk);
        set_req(0, 32'd6, 32'd8, 1'b0);
        push(0, 64'd48);
        wait_ack(1, n);
        check("rr_ack1_gap", 64'(n), 64'(MUL_LAT + 2));
        wait_ack(0, n);
        check("rr_ack0_gap", 64'(n), 64'(MUL_LAT + 3));
        wait_done(0, n);
        check("rr_done_lat", 64'(n), 64'(MUL_LAT + 1));

        // Basic 3*5 with cycle-exact latency.
        @(negedge clk);
        set_req(0, 32'd3, 32'd5, 1'b0);
        push(0, 64'd15);
        wait_ack(0, n);
        check("basic_ack_lat", 64'(n), 64'd1);
        check("basic_m_mul_at_ack", {63'b0, m_mul}, 64'd1);
        @(negedge clk);
        check("basic_m_mul_one_cycle", {63'b0, m_mul}, 64'd0);
        check("basic_busy", {63'b0, busy}, 64'd1);
        wait_done(0, n);
        check("basic_done_lat", 64'(n), 64'(MUL_LAT));

        // All-ones operands, then a back-to-back request for throughput.
        @(negedge clk);
        set_req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        push(0, 64'hFFFFFFFE00000001);
        wait_ack(0, n);
        check("ones_ack_lat", 64'(n), 64'd1);
        @(negedge clk);
        set_req(0, 32'h12345678, 32'h10, 1'b0);
        push(0, 64'h0000000123456780);
        wait_ack(0, n);
        check("tput_ack_gap", 64'(n), 64'(MUL_LAT + 2));
        wait_done(0, n);
        check("tput_done_lat", 64'(n), 64'(MUL_LAT + 1));

        // req1 raised during requester 0's WAIT is held off until IDLE.
        @(negedge clk);
        set_req(0, 32'd11, 32'd13, 1'b0);
        push(0, 64'd143);
        wait_ack(0, n);
        check("late_ack0_lat", 64'(n), 64'd1);
        @(negedge clk);
        @(negedge clk);
        set_req(1, 32'h10000, 32'h10000, 1'b0);
        push(1, 64'h0000000100000000);
        early = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ack1) early = 1'b1;
            if (done0) found = 1'b1;
        end
        check("late_no_early_ack1", {63'b0, early}, 64'd0);
        check("late_done0_seen", {63'b0, found}, 64'd1);
        wait_ack(1, n);
        check("late_ack1_gap", 64'(n), 64'd2);
        wait_done(1, n);
        check("late_done_lat", 64'(n), 64'(MUL_LAT + 1));

        // Signed flag handling and most-negative boundary.
`ifdef MUL_SCHEDULER_SIGNED_EN
        run_op("sgn_neg2x3", 0, 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFFFFFFFFFA);
        run_op("sgn_min_x1", 1, 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF80000000);
`else
        run_op("sgn_neg2x3", 0, 32'hFFFFFFFE, 32'd3, 1'b1, 64'h00000002FFFFFFFA);
        run_op("sgn_min_x1", 1, 32'h80000000, 32'd1, 1'b1, 64'h0000000080000000);
`endif
        run_op("uns_neg2x3", 0, 32'hFFFFFFFE, 32'd3, 1'b0, 64'h00000002FFFFFFFA);
        run_op("sgn_min_sq", 1, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);

        // Reset during WAIT discards the operation; next request served normally.
        @(negedge clk);
        set_req(0, 32'h55, 32'h66, 1'b0);
        wait_ack(0, n);
        check("rst_ack_lat", 64'(n), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        repeat (MUL_LAT + 6) @(negedge clk);
        run_op("post_rst", 0, 32'd7, 32'd9, 1'b0, 64'd63);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
